rv_lsu: RTL and testbench
=========================

// Module: rv_lsu
// PURPOSE
//  Parametrised load/store unit for the RV32I core memory stage. Accepts one load/store request from the
//  core, runs a handshaked data-memory transaction with byte enables and lane alignment, and returns
//  sign/zero-extended load data or an error on a one-cycle response. Sits between execute and write-back.
// PARAMETERS
//  WIDTH        32   data/address width; 32 or 64 (BYTES = WIDTH/8, OFF_W = log2(BYTES))
//  TIMEOUT_CYC  255  max cycles mem_req may wait for mem_ack before abort; 0 disables the timeout
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous active-high reset
//  req_valid  in   1        request present
//  req_ready  out  1        LSU can accept; high only in IDLE
//  req_we     in   1        1 = store, 0 = load
//  req_op     in   3        funct3: 000 B, 001 H, 010 W, 011 D (WIDTH=64 only), 100 BU, 101 HU, 110 WU (64 only)
//  req_addr   in   WIDTH    byte address
//  req_wdata  in   WIDTH    store data, right-aligned
//  rsp_valid  out  1        one-cycle response pulse
//  rsp_rdata  out  WIDTH    extended load data; 0 for stores and errors
//  rsp_err    out  1        illegal op, misalignment (when not split) or timeout
//  mem_req    out  1        bus request; held until mem_ack
//  mem_we     out  1        bus write
//  mem_addr   out  WIDTH    bus address, always BYTES-aligned
//  mem_be     out  BYTES    byte enables
//  mem_wdata  out  WIDTH    lane-shifted write data
//  mem_ack    in   1        bus completes the current beat; mem_rdata valid in the same cycle
//  mem_rdata  in   WIDTH    bus read data
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0; mem_req=0, mem_we=0, mem_addr=0,
//    mem_be=0, mem_wdata=0; timeout counter 0. rst mid-access drops mem_req at once; no response is issued.
//  - FSM IDLE -> ACC0 -> [ACC1] -> RESP -> IDLE. Accept on req_valid && req_ready (cycle 0).
//    Request fields are latched in that cycle.
//  - Illegal op or forbidden misalignment: IDLE -> RESP directly, rsp_err=1, no mem_req.
//  - ACC0/ACC1: mem_req=1 and all mem_* stable until mem_ack is seen.
//    mem_addr = addr & ~(BYTES-1) (ACC1: +BYTES). mem_be = size mask << offset, split across beats.
//    mem_wdata = wdata << 8*offset (ACC1 carries the spilled upper bytes in lower lanes).
//  - RESP: rsp_valid=1 for exactly one cycle, req_ready=0. Minimum latency: accept at 0, ack at 1, rsp at 2,
//    ready at 3.
//  - Loads: beat data is captured on ack, merged across beats, shifted right by offset, then sign-extended
//    (B/H/W) or zero-extended (BU/HU/WU).
//  - Timeout: counter increments every cycle mem_req=1 && !mem_ack. When it reaches TIMEOUT_CYC: drop mem_req,
//    go to RESP with rsp_err=1, rdata=0. Counter clears on each ack and in IDLE.
//  - Split store timing out in ACC1: ACC0 bytes stay written; rsp_err=1.
//  - mem_ack outside ACC0/ACC1 is ignored. req_valid while not ready is ignored; the requester holds it.
// CONFIGURATION
//  LSU_MISALIGN_SPLIT_EN defined: access with offset+size > BYTES runs as two aligned beats (ACC0 then ACC1)
//    and completes normally.
//  Undefined: any access not naturally aligned (addr % size != 0) returns rsp_err=1 with no bus activity.
//    ACC1 is never entered.
// STRUCTURE
//  Package lsu_pkg: op encodings (LSU_OP_B..LSU_OP_WU), state encoding, size-from-op function, BYTES/OFF_W
//    helpers.
//  Sub-module lsu_align: combinational lane shifter, byte-enable generator and load extender.
//    rv_lsu owns the FSM, request/beat registers and the timeout counter.
// TESTING (WIDTH=32 unless noted)
//  1 LW 0x100, ack at cycle 1, rdata 0xDEADBEEF -> mem_addr 0x100, be 1111; rsp at cycle 2 with 0xDEADBEEF,
//    err 0.
//  2 LB / LBU 0x103, rdata 0x80xxxxxx -> be 1000; rsp 0xFFFFFF80 / 0x00000080.
//  3 SH 0x102, wdata 0x0000ABCD -> mem_we 1, be 1100, mem_wdata 0xABCD0000; rsp rdata 0, err 0.
//  4 LW 0x101, beats 0x44332211 then 0x88776655. With macro: beats at 0x100 (be 1110) and 0x104 (be 0001),
//    rsp 0x55443322. Without macro: rsp_err 1, mem_req never high.
//  5 TIMEOUT_CYC=4, LW with mem_ack tied 0 -> mem_req high for 4 cycles then low; rsp_err 1; req_ready
//    returns 1.
//  6 rst pulsed while mem_req=1 in ACC0 -> all outputs at reset values immediately; no rsp_valid; next LW
//    completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 op codes, FSM states and size helpers.
package lsu_pkg;

    localparam logic [2:0] LSU_OP_B  = 3'b000;
    localparam logic [2:0] LSU_OP_H  = 3'b001;
    localparam logic [2:0] LSU_OP_W  = 3'b010;
    localparam logic [2:0] LSU_OP_D  = 3'b011;
    localparam logic [2:0] LSU_OP_BU = 3'b100;
    localparam logic [2:0] LSU_OP_HU = 3'b101;
    localparam logic [2:0] LSU_OP_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    function automatic int lsu_bytes(input int width);
        return width / 8;
    endfunction

    function automatic int lsu_off_w(input int width);
        return $clog2(width / 8);
    endfunction

    // Access size in bytes; 0 marks an encoding with no size.
    function automatic logic [3:0] lsu_size(input logic [2:0] op);
        case (op)
            LSU_OP_B, LSU_OP_BU: return 4'd1;
            LSU_OP_H, LSU_OP_HU: return 4'd2;
            LSU_OP_W, LSU_OP_WU: return 4'd4;
            LSU_OP_D:            return 4'd8;
            default:             return 4'd0;
        endcase
    endfunction

    function automatic logic lsu_op_legal(input logic [2:0] op, input int width);
        case (op)
            LSU_OP_B, LSU_OP_H, LSU_OP_W, LSU_OP_BU, LSU_OP_HU: return 1'b1;
            LSU_OP_D, LSU_OP_WU:                                return (width == 64);
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-enable/write-data shift across two beats and load merge/extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int BYTES = lsu_bytes(WIDTH),
    localparam int OFF_W = lsu_off_w(WIDTH)
) (
    input  logic [2:0]       i_op,
    input  logic [OFF_W-1:0] i_off,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [WIDTH-1:0] i_rdata0,
    input  logic [WIDTH-1:0] i_rdata1,
    output logic [BYTES-1:0] o_be0,
    output logic [BYTES-1:0] o_be1,
    output logic [WIDTH-1:0] o_wdata0,
    output logic [WIDTH-1:0] o_wdata1,
    output logic [WIDTH-1:0] o_rdata
);

    // Shift left then back right so the top bit of the access lands on the MSB for sign fill.
    function automatic logic [WIDTH-1:0] extend(input logic [WIDTH-1:0] v,
                                                input logic [3:0]       size,
                                                input logic             uns);
        logic signed [WIDTH-1:0] s;
        int                      lsh;
        lsh = WIDTH - 8 * int'(size);
        if (lsh < 0) lsh = 0;
        s = $signed(v << lsh);
        if (uns) begin
            extend = (v << lsh) >> lsh;
        end else begin
            s = s >>> lsh;
            extend = s;
        end
    endfunction

    logic [3:0]         w_size;
    logic [2*BYTES-1:0] w_mask;
    logic [2*BYTES-1:0] w_be;
    logic [2*WIDTH-1:0] w_wd;
    logic [WIDTH-1:0]   w_rd;

    always_comb begin
        w_size = lsu_size(i_op);
        w_mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < int'(w_size)) w_mask[i] = 1'b1;
        end
        w_be = w_mask << i_off;
        w_wd = {{WIDTH{1'b0}}, i_wdata} << {i_off, 3'b000};
        w_rd = WIDTH'({i_rdata1, i_rdata0} >> {i_off, 3'b000});
    end

    assign o_be0    = w_be[BYTES-1:0];
    assign o_be1    = w_be[2*BYTES-1:BYTES];
    assign o_wdata0 = w_wd[WIDTH-1:0];
    assign o_wdata1 = w_wd[2*WIDTH-1:WIDTH];
    assign o_rdata  = extend(w_rd, w_size, i_op[2]);

endmodule

// File: rtl/rv_lsu.sv
// RV32I/RV64I load/store unit: request latch, handshaked bus FSM with timeout, one-cycle response.
// Define LSU_MISALIGN_SPLIT_EN to run lane-crossing accesses as two aligned beats instead of faulting.
module rv_lsu
    import lsu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int TIMEOUT_CYC = 255,
    localparam int BYTES = lsu_bytes(WIDTH),
    localparam int OFF_W = lsu_off_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [BYTES-1:0] mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    lsu_state_e       r_state, w_state_nx;
    logic             r_we;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_beat0;
    logic [WIDTH-1:0] r_beat1;
    logic             r_err;
    logic             r_split;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0]       w_req_size;
    logic [OFF_W-1:0] w_req_off;
    logic             w_req_split;
    logic             w_req_bad;
    logic             w_accept;
    logic             w_in_acc;
    logic             w_timeout;
    logic [WIDTH-1:0] w_base;
    logic [BYTES-1:0] w_be0, w_be1;
    logic [WIDTH-1:0] w_wd0, w_wd1;
    logic [WIDTH-1:0] w_rdata_ext;

    assign w_req_size = lsu_size(req_op);
    assign w_req_off  = req_addr[OFF_W-1:0];

`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_req_split = (int'(w_req_off) + int'(w_req_size)) > BYTES;
    assign w_req_bad   = !lsu_op_legal(req_op, WIDTH);
`else
    assign w_req_split = 1'b0;
    assign w_req_bad   = !lsu_op_legal(req_op, WIDTH) ||
                         ((w_req_off & OFF_W'(int'(w_req_size) - 1)) != '0);
`endif

    assign w_accept  = req_valid && (r_state == ST_IDLE);
    assign w_in_acc  = (r_state == ST_ACC0) || (r_state == ST_ACC1);
    assign w_timeout = (TIMEOUT_CYC != 0) && w_in_acc && !mem_ack &&
                       (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_base    = r_addr & ~WIDTH'(BYTES - 1);

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .i_op     (r_op),
        .i_off    (r_addr[OFF_W-1:0]),
        .i_wdata  (r_wdata),
        .i_rdata0 (r_beat0),
        .i_rdata1 (r_beat1),
        .o_be0    (w_be0),
        .o_be1    (w_be1),
        .o_wdata0 (w_wd0),
        .o_wdata1 (w_wd1),
        .o_rdata  (w_rdata_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_err    = 1'b0;
        rsp_rdata  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nx = w_req_bad ? ST_RESP : ST_ACC0;
            end
            ST_ACC0: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = w_base;
                mem_be    = w_be0;
                mem_wdata = w_wd0;
                if (mem_ack)        w_state_nx = r_split ? ST_ACC1 : ST_RESP;
                else if (w_timeout) w_state_nx = ST_RESP;
            end
            ST_ACC1: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = w_base + WIDTH'(BYTES);
                mem_be    = w_be1;
                mem_wdata = w_wd1;
                if (mem_ack || w_timeout) w_state_nx = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid  = 1'b1;
                rsp_err    = r_err;
                rsp_rdata  = (r_err || r_we) ? '0 : w_rdata_ext;
                w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Beat buffers start at zero so a single-beat access merges against an empty upper half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_beat0 <= '0;
            r_beat1 <= '0;
            r_err   <= 1'b0;
            r_split <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_op    <= req_op;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_err   <= w_req_bad;
                r_split <= w_req_split;
                r_beat0 <= '0;
                r_beat1 <= '0;
            end
            if (w_in_acc && mem_ack) begin
                if (r_state == ST_ACC0) r_beat0 <= mem_rdata;
                else                    r_beat1 <= mem_rdata;
            end
            if (w_timeout) r_err <= 1'b1;
            if (!w_in_acc || mem_ack) r_cnt <= '0;
            else                      r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu (WIDTH=32, TIMEOUT_CYC=4): vector table plus timeout/reset/stray-ack sequences.
module tb_rv_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv_lsu #(.WIDTH(32), .TIMEOUT_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] beat0;
        logic [31:0] beat1;
        int          delay;
        int          nbeats;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] beat0, input logic [31:0] beat1,
                                input int delay, input int nbeats,
                                input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                                input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
                                input logic err, input logic [31:0] rdata);
        vec_t v;
        v.we = we; v.op = op; v.addr = addr; v.wdata = wdata; v.beat0 = beat0; v.beat1 = beat1;
        v.delay = delay; v.nbeats = nbeats; v.a0 = a0; v.be0 = be0; v.wd0 = wd0;
        v.a1 = a1; v.be1 = be1; v.wd1 = wd1; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        int i;
        for (i = 0; i < 10 && !req_ready; i++) @(negedge clk);
        if (!req_ready) check({nm, " ready wait"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int  cyc, nb, wt;
        bit  done, saw_req;
        @(negedge clk);
        wait_ready(nm);
        req_valid = 1'b1; req_we = v.we; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
        nb = 0; wt = 0; done = 0; saw_req = 0;
        for (cyc = 1; cyc <= 20 && !done; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_ack   = 1'b0;
            if (rsp_valid) begin
                check({nm, " rsp_err"}, 32'(rsp_err), 32'(v.err));
                check({nm, " rsp_rdata"}, rsp_rdata, v.rdata);
                check({nm, " beats"}, 32'(nb), 32'(v.nbeats));
                check({nm, " mem_req seen"}, 32'(saw_req), 32'(v.nbeats != 0));
                check({nm, " latency"}, 32'(cyc), 32'(1 + v.nbeats * (v.delay + 1)));
                done = 1;
            end else if (mem_req) begin
                saw_req = 1;
                if (wt == v.delay) begin
                    check({nm, " mem_we"}, 32'(mem_we), 32'(v.we));
                    if (nb == 0) begin
                        check({nm, " addr0"}, mem_addr, v.a0);
                        check({nm, " be0"}, 32'(mem_be), 32'(v.be0));
                        check({nm, " wdata0"}, mem_wdata, v.wd0);
                        mem_rdata = v.beat0;
                    end else begin
                        check({nm, " addr1"}, mem_addr, v.a1);
                        check({nm, " be1"}, 32'(mem_be), 32'(v.be1));
                        check({nm, " wdata1"}, mem_wdata, v.wd1);
                        mem_rdata = v.beat1;
                    end
                    mem_ack = 1'b1;
                    nb++;
                    wt = 0;
                end else begin
                    wt++;
                end
            end
        end
        if (!done) check({nm, " response timeout"}, 32'(done), 32'd1);
        @(negedge clk);
        check({nm, " rsp one-cycle"}, 32'(rsp_valid), 32'd0);
        check({nm, " ready after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int  cnt;
        bit  got;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b0; req_addr = '0; req_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        //            we   op      addr          wdata         beat0         beat1        dly nb a0            be0      wd0           a1            be1      wd1           err   rdata
        vecs[0]  = mk(1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 32'h0,        0, 1, 32'h100, 4'b1111, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b0, 32'hDEADBEEF);
        vecs[1]  = mk(1'b0, 3'b000, 32'h103, 32'h0,        32'h80123456, 32'h0,        0, 1, 32'h100, 4'b1000, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b0, 32'hFFFFFF80);
        vecs[2]  = mk(1'b0, 3'b100, 32'h103, 32'h0,        32'h80123456, 32'h0,        0, 1, 32'h100, 4'b1000, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b0, 32'h00000080);
        vecs[3]  = mk(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0,        32'h0,        0, 1, 32'h100, 4'b1100, 32'hABCD0000, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0);
        vecs[4]  = mk(1'b0, 3'b001, 32'h102, 32'h0,        32'h80011234, 32'h0,        2, 1, 32'h100, 4'b1100, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b0, 32'hFFFF8001);
        vecs[5]  = mk(1'b0, 3'b101, 32'h100, 32'h0,        32'h1234F00D, 32'h0,        0, 1, 32'h100, 4'b0011, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b0, 32'h0000F00D);
        vecs[6]  = mk(1'b1, 3'b000, 32'h101, 32'h123456A5, 32'h0,        32'h0,        0, 1, 32'h100, 4'b0010, 32'h3456A500, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0);
        vecs[7]  = mk(1'b1, 3'b010, 32'h10C, 32'hCAFEF00D, 32'h0,        32'h0,        1, 1, 32'h10C, 4'b1111, 32'hCAFEF00D, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h0);
        vecs[8]  = mk(1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b1, 32'h0);
        vecs[9]  = mk(1'b0, 3'b111, 32'h100, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b1, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
        vecs[10] = mk(1'b0, 3'b010, 32'h101, 32'h0,        32'h44332211, 32'h88776655, 0, 2, 32'h100, 4'b1110, 32'h0,        32'h104, 4'b0001, 32'h0,        1'b0, 32'h55443322);
        vecs[11] = mk(1'b1, 3'b010, 32'h102, 32'hAABBCCDD, 32'h0,        32'h0,        0, 2, 32'h100, 4'b1100, 32'hCCDD0000, 32'h104, 4'b0011, 32'h0000AABB, 1'b0, 32'h0);
        vecs[12] = mk(1'b0, 3'b001, 32'h103, 32'h0,        32'h80AABBCC, 32'h11223380, 1, 2, 32'h100, 4'b1000, 32'h0,        32'h104, 4'b0001, 32'h0,        1'b0, 32'hFFFF8080);
        vecs[13] = mk(1'b0, 3'b001, 32'h101, 32'h0,        32'h00ABCD00, 32'h0,        0, 1, 32'h100, 4'b0110, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b0, 32'hFFFFABCD);
`else
        vecs[10] = mk(1'b0, 3'b010, 32'h101, 32'h0,        32'h44332211, 32'h88776655, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b1, 32'h0);
        vecs[11] = mk(1'b1, 3'b010, 32'h102, 32'hAABBCCDD, 32'h0,        32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b1, 32'h0);
        vecs[12] = mk(1'b0, 3'b001, 32'h103, 32'h0,        32'h80AABBCC, 32'h11223380, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b1, 32'h0);
        vecs[13] = mk(1'b0, 3'b001, 32'h101, 32'h0,        32'h00ABCD00, 32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b1, 32'h0);
`endif

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_be", 32'(mem_be), 32'd0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Timeout: no ack, mem_req must be high for exactly TIMEOUT_CYC cycles
        @(negedge clk);
        wait_ready("timeout");
        req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 32'h200; req_wdata = '0;
        cnt = 0; got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_req) cnt++;
            if (rsp_valid) begin
                got = 1;
                check("timeout rsp_err", 32'(rsp_err), 32'd1);
                check("timeout rsp_rdata", rsp_rdata, 32'h0);
                check("timeout mem_req cycles", 32'(cnt), 32'd4);
            end
        end
        if (!got) check("timeout response", 32'(got), 32'd1);
        @(negedge clk);
        check("timeout ready", 32'(req_ready), 32'd1);
        check("timeout mem_req low", 32'(mem_req), 32'd0);

        // Asynchronous reset in the middle of an access
        wait_ready("midrst");
        req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 32'h300;
        @(negedge clk);
        req_valid = 1'b0;
        check("midrst mem_req before", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst mem_req", 32'(mem_req), 32'd0);
        check("midrst req_ready", 32'(req_ready), 32'd1);
        check("midrst mem_addr", mem_addr, 32'h0);
        check("midrst mem_be", 32'(mem_be), 32'd0);
        check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        got = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        check("midrst no response", 32'(got), 32'd0);
        run_vec(vecs[0], "post-rst LW");

        // Stray ack while idle
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        check("idle ack rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle ack ready", 32'(req_ready), 32'd1);
        check("idle ack mem_req", 32'(mem_req), 32'd0);
        mem_ack = 1'b0;
        run_vec(vecs[1], "after stray ack");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
